// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and memory-wait stalls,
// the fixed JALR stall sequence, IF flush on taken control flow, and perf counters.
module hazard_sequencer #(
  parameter int JALR_STALL = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             cu_jalr,
  input  logic             cu_jump,
  input  logic             br_taken,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd,
  input  logic             mem_busy,
  input  logic             clr_cnt,
  output logic             hz_bubble,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             hz_IF_flush,
  output logic             hz_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // state  | meaning
  // RUN    | normal issue; hazards resolved one cycle at a time
  // JSTALL | JALR target not yet available; jcnt stall cycles remain before release
  // MWAIT  | data memory busy; whole pipeline frozen until one cycle after busy drops
  typedef enum logic [1:0] {RUN, JSTALL, MWAIT} state_t;

  state_t     state, next_state;
  logic [2:0] jcnt, next_jcnt;
  logic       load_use;

  assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    next_state  = state;
    next_jcnt   = jcnt;
    hz_bubble   = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    hz_IF_flush = 1'b0;
    hz_freeze   = 1'b0;
    if (rst) begin
      hz_bubble  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_busy) begin
            hz_freeze  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            next_state = MWAIT;
          end else if (load_use) begin
            hz_bubble  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
          end else if (cu_jalr) begin
            hz_bubble  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            next_jcnt  = 3'(JALR_STALL - 1);
            next_state = JSTALL;
          end else if (cu_jump || br_taken) begin
            hz_IF_flush = 1'b1;
          end
        end
        JSTALL: begin
          if (mem_busy) begin
            hz_freeze  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
          end else if (jcnt != 3'd0) begin
            hz_bubble  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            next_jcnt  = jcnt - 3'd1;
          end else begin
            hz_IF_flush = 1'b1;
            next_state  = RUN;
          end
        end
        MWAIT: begin
          hz_freeze  = 1'b1;
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          if (!mem_busy) next_state = RUN;
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      jcnt      <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= next_state;
      jcnt  <= next_jcnt;
      if (clr_cnt) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        // counters stick at all-ones rather than wrapping
        if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        if (hz_IF_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule
